freq_meter: RTL and testbench

Gated frequency meter and the receiving end of the divided-clock path. It counts rising edges of an asynchronous slow input, such as a divided clock or an external square wave, over a fixed gate window timed from the 50 MHz system clock. At the end of each window it publishes the count as a frequency in edges per gate. The result drives the hex/BCD display counters and the self-check of clock-divider outputs.

---
 rtl/freq_meter_pkg.sv | 20 ++
 rtl/freq_meter_bin2bcd_seq.sv | 95 +++++++++
 rtl/freq_meter.sv | 116 +++++++++++
 tb/tb_freq_meter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter: default gate lengths,
// the BCD converter state encoding and the double-dabble digit adjust.
// Optional feature macro: FREQ_METER_BCD_EN (adds the BCD converter).
package freq_meter_pkg;

    localparam int DEFAULT_GATE_CYCLES = 50_000_000;
    localparam int SIM_GATE_CYCLES     = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // Add 3 to any BCD digit of 5 or more before it is shifted left.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

endpackage

// File: rtl/freq_meter_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter used behind the meter.
// One bit is consumed per cycle; digits above DIGITS are dropped.
// Only instantiated when FREQ_METER_BCD_EN is defined.
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int CNT_W  = 25,
    parameter int DIGITS = 8
) (
    input  logic                clk_in,
    input  logic                nReset,
    input  logic                start,
    input  logic [CNT_W-1:0]    bin,
    output logic [4*DIGITS-1:0] bcd,
    output logic                done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SC_W  = $clog2(CNT_W + 1);

    bcd_state_t       state_q, state_d;
    logic [CNT_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] acc_q, acc_d;
    logic [BCD_W-1:0] acc_adj;
    logic [SC_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             done_q, done_d;

    // Apply the add-3 correction to every digit of the accumulator.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            acc_adj[4*i +: 4] = dabble_adjust(acc_q[4*i +: 4]);
        end
    end

    // IDLE loads the value, SHIFT runs CNT_W correct-and-shift steps, DONE publishes.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        acc_d       = acc_q;
        shift_cnt_d = shift_cnt_q;
        bcd_d       = bcd_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d       = bin;
                    acc_d       = '0;
                    shift_cnt_d = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                acc_d       = (acc_adj << 1) | BCD_W'(bin_q[CNT_W-1]);
                bin_d       = bin_q << 1;
                shift_cnt_d = shift_cnt_q + SC_W'(1);
                if (shift_cnt_q == SC_W'(CNT_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Converter registers; reset returns the FSM to IDLE with a cleared result.
    always_ff @(posedge clk_in or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            acc_q       <= '0;
            shift_cnt_q <= '0;
            bcd_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            acc_q       <= acc_d;
            shift_cnt_q <= shift_cnt_d;
            bcd_q       <= bcd_d;
            done_q      <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a
// free-running window of GATE_CYCLES clk_in cycles and publishes the count.
// Optional feature macro: FREQ_METER_BCD_EN (adds bcd_out/bcd_valid).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int CNT_W       = 25,
    parameter int DIGITS      = 8
) (
    input  logic                clk_in,
    input  logic                nReset,
    input  logic                sig_in,
    output logic [CNT_W-1:0]    freq_out,
    output logic                freq_valid,
    output logic                ovf
`ifdef FREQ_METER_BCD_EN
    ,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                bcd_valid
`endif
);

    localparam int               GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    if (GATE_CYCLES < 2 || DIGITS < 1) begin : g_param_chk
        $error("freq_meter: GATE_CYCLES must be >= 2 and DIGITS >= 1");
    end
`ifdef FREQ_METER_BCD_EN
    if (GATE_CYCLES <= CNT_W + 2) begin : g_bcd_chk
        $error("freq_meter: GATE_CYCLES must exceed CNT_W+2 so BCD finishes in one window");
    end
`endif

    logic [2:0]        sync_q, sync_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  freq_out_q, freq_out_d;
    logic              freq_valid_q, freq_valid_d;
    logic              ovf_q, ovf_d;
    logic              edge_pulse;
    logic              edge_lost;
    logic [CNT_W-1:0]  edge_next;
    logic              window_close;

    // Two synchronizer stages followed by an edge-detect stage.
    always_comb begin
        sync_d     = {sync_q[1:0], sig_in};
        edge_pulse = sync_q[1] & ~sync_q[2];
    end

    // Gate timing, saturating edge count and the close-cycle publish; an edge on
    // the close cycle is folded into the value being published.
    always_comb begin
        edge_lost    = edge_pulse && (edge_cnt_q == CNT_MAX);
        edge_next    = (edge_pulse && !edge_lost) ? (edge_cnt_q + CNT_W'(1)) : edge_cnt_q;
        window_close = (gate_cnt_q == GATE_LAST);
        gate_cnt_d   = gate_cnt_q + GATE_W'(1);
        edge_cnt_d   = edge_next;
        sat_d        = sat_q | edge_lost;
        freq_out_d   = freq_out_q;
        ovf_d        = ovf_q;
        freq_valid_d = 1'b0;
        if (window_close) begin
            gate_cnt_d   = '0;
            edge_cnt_d   = '0;
            sat_d        = 1'b0;
            freq_out_d   = edge_next;
            ovf_d        = sat_q | edge_lost;
            freq_valid_d = 1'b1;
        end
    end

    // All meter state clears on reset so the next window is a full one.
    always_ff @(posedge clk_in or negedge nReset) begin
        if (!nReset) begin
            sync_q       <= '0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            freq_out_q   <= '0;
            freq_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            freq_out_q   <= freq_out_d;
            freq_valid_q <= freq_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign freq_out   = freq_out_q;
    assign freq_valid = freq_valid_q;
    assign ovf        = ovf_q;

`ifdef FREQ_METER_BCD_EN
    bin2bcd_seq #(
        .CNT_W  (CNT_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk_in (clk_in),
        .nReset (nReset),
        .start  (freq_valid_q),
        .bin    (freq_out_q),
        .bcd    (bcd_out),
        .done   (bcd_valid)
    );
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances share clock and reset, an
// 8-bit meter for tone/boundary/reset cases and a 3-bit meter for overflow.
module tb_freq_meter;
    import freq_meter_pkg::*;

    logic        clk_in = 1'b0;
    logic        nReset = 1'b0;
    logic        sig8   = 1'b0;
    logic        sig3   = 1'b0;
    logic [7:0]  freq8;
    logic        fv8, ovf8;
    logic [2:0]  freq3;
    logic        fv3, ovf3;
`ifdef FREQ_METER_BCD_EN
    logic [11:0] bcd8, bcd3;
    logic        bv8, bv3;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int half8  = 0;
    int ph8    = 0;
    int half3  = 0;
    int ph3    = 0;

    freq_meter #(.GATE_CYCLES(SIM_GATE_CYCLES), .CNT_W(8), .DIGITS(3)) dut8 (
        .clk_in     (clk_in),
        .nReset     (nReset),
        .sig_in     (sig8),
        .freq_out   (freq8),
        .freq_valid (fv8),
        .ovf        (ovf8)
`ifdef FREQ_METER_BCD_EN
        ,
        .bcd_out    (bcd8),
        .bcd_valid  (bv8)
`endif
    );

    freq_meter #(.GATE_CYCLES(SIM_GATE_CYCLES), .CNT_W(3), .DIGITS(3)) dut3 (
        .clk_in     (clk_in),
        .nReset     (nReset),
        .sig_in     (sig3),
        .freq_out   (freq3),
        .freq_valid (fv3),
        .ovf        (ovf3)
`ifdef FREQ_METER_BCD_EN
        ,
        .bcd_out    (bcd3),
        .bcd_valid  (bv3)
`endif
    );

    initial forever #5 clk_in = ~clk_in;

    // Compare one observed value with its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n cycles; inputs change on the falling edge and tones toggle every half cycles.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge clk_in);
            cyc++;
            if (half8 > 0) begin
                ph8++;
                if (ph8 >= half8) begin
                    ph8  = 0;
                    sig8 = ~sig8;
                end
            end
            if (half3 > 0) begin
                ph3++;
                if (ph3 >= half3) begin
                    ph3  = 0;
                    sig3 = ~sig3;
                end
            end
        end
    endtask

    // Select which DUT pulse output a wait refers to.
    function automatic logic pulseOf(input int which);
        case (which)
            0:       return fv8;
            2:       return fv3;
`ifdef FREQ_METER_BCD_EN
            1:       return bv8;
            3:       return bv3;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Step until the selected pulse is seen or the budget runs out; returns the cycle stamp.
    task automatic waitPulse(input int which, input int budget, input string tag, output int at);
        int n;
        n = 0;
        do begin
            applyStimulus(1);
            n++;
        end while (!pulseOf(which) && n < budget);
        checkOutput({tag, "_seen"}, 32'(pulseOf(which)), 32'd1);
        at = cyc;
    endtask

    initial begin
        int tFv;
        int tPrev;
        int tB;
        int n;
        logic stale;

        // Reset with idle input: everything must read zero.
        applyStimulus(5);
        checkOutput("rst_freq", 32'(freq8), 32'd0);
        checkOutput("rst_valid", 32'(fv8), 32'd0);
        checkOutput("rst_ovf", 32'(ovf8), 32'd0);
        checkOutput("rst_valid3", 32'(fv3), 32'd0);
`ifdef FREQ_METER_BCD_EN
        checkOutput("rst_bcd", 32'(bcd8), 32'd0);
        checkOutput("rst_bcd_valid", 32'(bv8), 32'd0);
`endif
        nReset = 1'b1;
        tPrev  = cyc;

        // Idle windows: valid every 20 cycles with a zero count.
        for (int w = 0; w < 2; w++) begin
            waitPulse(0, 25, "idle_fv", tFv);
            checkOutput("idle_period", 32'(tFv - tPrev), 32'd20);
            checkOutput("idle_freq", 32'(freq8), 32'd0);
            checkOutput("idle_ovf", 32'(ovf8), 32'd0);
            tPrev = tFv;
        end

        // Period-4 tone: 5 edges per window from the first full window on.
        half8 = 2;
        ph8   = 0;
        waitPulse(0, 25, "tone_first", tPrev);
        for (int w = 0; w < 3; w++) begin
            waitPulse(0, 25, "tone_fv", tFv);
            checkOutput("tone_period", 32'(tFv - tPrev), 32'd20);
            checkOutput("tone_freq", 32'(freq8), 32'd5);
            checkOutput("tone_ovf", 32'(ovf8), 32'd0);
            applyStimulus(1);
            checkOutput("tone_fv_width", 32'(fv8), 32'd0);
`ifdef FREQ_METER_BCD_EN
            waitPulse(1, 15, "tone_bv", tB);
            checkOutput("tone_bcd_lat", 32'(tB - tFv), 32'd10);
            checkOutput("tone_bcd", 32'(bcd8), 32'h005);
`endif
            tPrev = tFv;
        end

        // Single rise timed so its edge pulse sits on the close cycle.
        half8 = 0;
        sig8  = 1'b0;
        waitPulse(0, 25, "bnd_align", tFv);
        applyStimulus(17);
        sig8 = 1'b1;
        waitPulse(0, 25, "bnd_fv", tFv);
        checkOutput("bnd_freq", 32'(freq8), 32'd1);
        waitPulse(0, 25, "bnd_next_fv", tFv);
        checkOutput("bnd_next_freq", 32'(freq8), 32'd0);

        // Overflow on the 3-bit meter: 10 edges per window saturate at 7.
        half3 = 1;
        ph3   = 0;
        waitPulse(2, 25, "ovf_first", tFv);
        waitPulse(2, 25, "ovf_fv", tFv);
        checkOutput("ovf_freq", 32'(freq3), 32'd7);
        checkOutput("ovf_flag", 32'(ovf3), 32'd1);
`ifdef FREQ_METER_BCD_EN
        waitPulse(3, 10, "ovf_bv", tB);
        checkOutput("ovf_bcd_lat", 32'(tB - tFv), 32'd5);
        checkOutput("ovf_bcd", 32'(bcd3), 32'h007);
`else
        applyStimulus(5);
`endif
        // Period 8 phased so rises land at gate counts 2, 10 and 18 of the checked window.
        sig3  = 1'b1;
        ph3   = 1;
        half3 = 4;
        waitPulse(2, 25, "slow_first", tFv);
        waitPulse(2, 25, "slow_fv", tFv);
        checkOutput("slow_freq", 32'(freq3), 32'd3);
        checkOutput("slow_ovf", 32'(ovf3), 32'd0);

        // Reset at gate count 10 during the period-4 tone.
        half8 = 2;
        ph8   = 0;
        waitPulse(0, 25, "mid_first", tFv);
        waitPulse(0, 25, "mid_fv", tFv);
        checkOutput("mid_freq", 32'(freq8), 32'd5);
        applyStimulus(10);
        nReset = 1'b0;
        #1;
        checkOutput("mid_rst_freq", 32'(freq8), 32'd0);
        checkOutput("mid_rst_valid", 32'(fv8), 32'd0);
        checkOutput("mid_rst_ovf3", 32'(ovf3), 32'd0);
`ifdef FREQ_METER_BCD_EN
        checkOutput("mid_rst_bcd", 32'(bcd8), 32'd0);
        checkOutput("mid_rst_bv", 32'(bv8), 32'd0);
`endif
        applyStimulus(3);
        nReset = 1'b1;
        tPrev  = cyc;
        stale  = 1'b0;
        n      = 0;
        do begin
            applyStimulus(1);
            n++;
`ifdef FREQ_METER_BCD_EN
            if (bv8) stale = 1'b1;
`endif
        end while (!fv8 && n < 25);
        checkOutput("mid_fv_seen", 32'(fv8), 32'd1);
        checkOutput("mid_first_period", 32'(cyc - tPrev), 32'd20);
        checkOutput("mid_stale_bv", 32'(stale), 32'd0);
`ifdef FREQ_METER_BCD_EN
        tFv = cyc;
        waitPulse(1, 15, "mid_bv", tB);
        checkOutput("mid_bcd_lat", 32'(tB - tFv), 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
